// File: rtl/mont_pkg.sv
// Shared types and constants for the Montgomery square-and-multiply exponentiation controller.
package mont_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StToMont,
    StLead,
    StNext,
    StSquare,
    StMultiply,
    StFromMont,
    StDone
  } mont_exp_state_t;

  typedef enum logic [1:0] {
    OpToMont,
    OpSquare,
    OpMult,
    OpFromMont
  } mont_op_sel_t;

  // Montgomery multiply by 1 strips one R factor, leaving the plain residue.
  localparam int unsigned MontOne = 1;

  function automatic logic is_op_state(mont_exp_state_t st);
    return st inside {StToMont, StSquare, StMultiply, StFromMont};
  endfunction

endpackage

// File: rtl/mont_exp_scan.sv
// MSB-first exponent scanner: shift register plus count of bits not yet consumed.
module mont_exp_scan #(
  parameter int unsigned EXP_WIDTH = 512
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 load_i,
  input  logic                 shift_i,
  input  logic [EXP_WIDTH-1:0] exp_i,
  output logic                 msb_o,
  output logic                 last_o,
  output logic                 done_o
);

  localparam int unsigned CntW = $clog2(EXP_WIDTH + 1);

  logic [EXP_WIDTH-1:0] exp_q, exp_d;
  logic [CntW-1:0]      bits_left_q, bits_left_d;

  always_comb begin
    exp_d       = exp_q;
    bits_left_d = bits_left_q;
    if (load_i) begin
      exp_d       = exp_i;
      bits_left_d = CntW'(EXP_WIDTH);
    end else if (shift_i) begin
      exp_d       = {exp_q[EXP_WIDTH-2:0], 1'b0};
      bits_left_d = bits_left_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      exp_q       <= '0;
      bits_left_q <= '0;
    end else begin
      exp_q       <= exp_d;
      bits_left_q <= bits_left_d;
    end
  end

  assign msb_o  = exp_q[EXP_WIDTH-1];
  // last_o: the bit now at the MSB is the final one to be consumed.
  assign last_o = (bits_left_q == CntW'(1));
  assign done_o = (bits_left_q == '0);

endmodule

// File: rtl/mont_exp_ctrl.sv
// Left-to-right square-and-multiply controller driving one shared Montgomery multiplier.
module mont_exp_ctrl
  import mont_pkg::*;
#(
  parameter int unsigned WIDTH     = 512,
  parameter int unsigned EXP_WIDTH = 512
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 valid_in,
  input  logic [WIDTH-1:0]     base_in,
  input  logic [EXP_WIDTH-1:0] exp_in,
  input  logic [WIDTH-1:0]     r2_in,
  output logic [WIDTH-1:0]     result_out,
  output logic                 valid_out,
  output logic                 busy_out,
  output logic [WIDTH-1:0]     mm_a_out,
  output logic [WIDTH-1:0]     mm_b_out,
  output logic                 mm_valid_out,
  input  logic                 mm_busy_in,
  input  logic [WIDTH-1:0]     mm_result_in,
  input  logic                 mm_valid_in
);

  mont_exp_state_t state_q, state_d;
  mont_op_sel_t    op_sel;
  logic [WIDTH-1:0] base_q, base_d, r2_q, r2_d, base_m_q, base_m_d;
  logic [WIDTH-1:0] acc_q, acc_d, result_q, result_d;
  logic             busy_q, busy_d, issued_q, issued_d;
  logic             op_active, op_issue, op_done;
  logic             scan_load, scan_shift, scan_msb, scan_last, scan_done;

  mont_exp_scan #(
    .EXP_WIDTH(EXP_WIDTH)
  ) u_scan (
    .clk_i  (clk_in),
    .rst_ni (rst_n_in),
    .load_i (scan_load),
    .shift_i(scan_shift),
    .exp_i  (exp_in),
    .msb_o  (scan_msb),
    .last_o (scan_last),
    .done_o (scan_done)
  );

  // issued_q guards against a second issue and filters results that arrive when nothing is owed.
  assign op_active = is_op_state(state_q);
  assign op_issue  = op_active && !issued_q && !mm_busy_in;
  assign op_done   = op_active && issued_q && mm_valid_in;

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    r2_d       = r2_q;
    base_m_d   = base_m_q;
    acc_d      = acc_q;
    result_d   = result_q;
    busy_d     = busy_q;
    issued_d   = op_done ? 1'b0 : (op_issue ? 1'b1 : issued_q);
    scan_load  = 1'b0;
    scan_shift = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (valid_in) begin
          base_d    = base_in;
          r2_d      = r2_in;
          busy_d    = 1'b1;
          scan_load = 1'b1;
          if (exp_in == '0) begin
            result_d = WIDTH'(MontOne);
            state_d  = StDone;
          end else begin
            state_d = StToMont;
          end
        end
      end
      StToMont: begin
        if (op_done) begin
          base_m_d = mm_result_in;
          state_d  = StLead;
        end
      end
      StLead: begin
        scan_shift = 1'b1;
        // The leading one needs no multiply; its step decision is taken here directly.
        if (scan_msb) begin
          acc_d   = base_m_q;
          state_d = scan_last ? StFromMont : StSquare;
        end
      end
      StNext: begin
        state_d = scan_done ? StFromMont : StSquare;
      end
      StSquare: begin
        if (op_done) begin
          acc_d = mm_result_in;
          if (scan_msb) begin
            state_d = StMultiply;
          end else begin
            scan_shift = 1'b1;
            state_d    = StNext;
          end
        end
      end
      StMultiply: begin
        if (op_done) begin
          acc_d      = mm_result_in;
          scan_shift = 1'b1;
          state_d    = StNext;
        end
      end
      StFromMont: begin
        if (op_done) begin
          result_d = mm_result_in;
          state_d  = StDone;
        end
      end
      StDone: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    op_sel = OpToMont;
    unique case (state_q)
      StSquare:   op_sel = OpSquare;
      StMultiply: op_sel = OpMult;
      StFromMont: op_sel = OpFromMont;
      default:    op_sel = OpToMont;
    endcase
  end

  always_comb begin
    mm_a_out = '0;
    mm_b_out = '0;
    if (op_active) begin
      unique case (op_sel)
        OpToMont:   begin mm_a_out = base_q; mm_b_out = r2_q;              end
        OpSquare:   begin mm_a_out = acc_q;  mm_b_out = acc_q;             end
        OpMult:     begin mm_a_out = acc_q;  mm_b_out = base_m_q;          end
        OpFromMont: begin mm_a_out = acc_q;  mm_b_out = WIDTH'(MontOne);   end
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q  <= StIdle;
      base_q   <= '0;
      r2_q     <= '0;
      base_m_q <= '0;
      acc_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      issued_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      r2_q     <= r2_d;
      base_m_q <= base_m_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      issued_q <= issued_d;
    end
  end

  assign mm_valid_out = op_issue;
  assign result_out   = result_q;
  assign valid_out    = (state_q == StDone);
  assign busy_out     = busy_q;

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Directed and random checks of mont_exp_ctrl against a behavioural Montgomery unit (N=241, L=3).
module tb_mont_exp_ctrl;

  localparam int N     = 241;
  localparam int RINV  = 225;  // 256^-1 mod 241
  localparam int R2    = 225;  // 256^2 mod 241
  localparam int LAT   = 3;

  logic       clk_in = 1'b0;
  logic       rst_n_in;
  logic       valid_in;
  logic [7:0] base_in, exp_in, r2_in;
  logic [7:0] result_out, mm_a_out, mm_b_out, mm_result_in;
  logic       valid_out, busy_out, mm_valid_out, mm_busy_in, mm_valid_in;

  int n_checks = 0;
  int n_errors = 0;
  int issue_cnt = 0;
  int overlap_cnt = 0;
  int mm_cnt = 0;
  int mm_res = 0;

  always #5 clk_in = ~clk_in;

  mont_exp_ctrl #(
    .WIDTH    (8),
    .EXP_WIDTH(8)
  ) dut (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .valid_in    (valid_in),
    .base_in     (base_in),
    .exp_in      (exp_in),
    .r2_in       (r2_in),
    .result_out  (result_out),
    .valid_out   (valid_out),
    .busy_out    (busy_out),
    .mm_a_out    (mm_a_out),
    .mm_b_out    (mm_b_out),
    .mm_valid_out(mm_valid_out),
    .mm_busy_in  (mm_busy_in),
    .mm_result_in(mm_result_in),
    .mm_valid_in (mm_valid_in)
  );

  // Behavioural multiplier: result strobe LAT cycles after the issue cycle; keeps running across reset.
  always @(posedge clk_in) begin
    bit pending;
    pending = (mm_cnt > 0) || mm_valid_in;
    mm_valid_in <= 1'b0;
    if (mm_cnt > 0) begin
      mm_cnt = mm_cnt - 1;
      if (mm_cnt == 0) begin
        mm_valid_in  <= 1'b1;
        mm_result_in <= 8'(mm_res);
      end
    end
    if (mm_valid_out) begin
      if (pending) overlap_cnt++;
      mm_res = (int'(mm_a_out) * int'(mm_b_out) * RINV) % N;
      mm_cnt = LAT - 1;
      issue_cnt++;
    end
  end

  task automatic check_eq(input string tag, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  function automatic int pow_ref(input logic [7:0] b, input logic [7:0] e);
    int r = 1;
    for (int i = 7; i >= 0; i--) begin
      r = (r * r) % N;
      if (e[i]) r = (r * int'(b)) % N;
    end
    return r;
  endfunction

  function automatic int top_bits(input logic [7:0] e);
    int n = 0;
    for (int i = 0; i < 8; i++) if (e[i]) n = i + 1;
    return n;
  endfunction

  task automatic run_exp(input string tag, input logic [7:0] b, input logic [7:0] e,
                         input int busy_cycles, input int pulse_cyc);
    int n, k, exp_t, exp_iss, seen, iss0;
    bit proto_ok;
    n = top_bits(e);
    k = $countones(e);
    exp_iss = (e == 0) ? 0 : n + k;
    exp_t   = (e == 0) ? 1 : (LAT + 1) * (n + k) + (8 - n) + n + 1 + busy_cycles;
    @(negedge clk_in);
    base_in    = b;
    exp_in     = e;
    r2_in      = 8'(R2);
    valid_in   = 1'b1;
    mm_busy_in = (busy_cycles > 0);
    iss0       = issue_cnt;
    seen       = 0;
    proto_ok   = 1'b1;
    for (int cyc = 1; cyc <= 2000 && seen == 0; cyc++) begin
      @(negedge clk_in);
      valid_in = (cyc == pulse_cyc);
      if (cyc == pulse_cyc) begin
        base_in = 8'd3;
        exp_in  = 8'h02;
      end
      mm_busy_in = (cyc <= busy_cycles);
      if (!busy_out) proto_ok = 1'b0;
      if (valid_out) seen = cyc;
    end
    valid_in = 1'b0;
    check_eq({tag, ".result"}, int'(result_out), pow_ref(b, e));
    check_eq({tag, ".latency"}, seen, exp_t);
    check_eq({tag, ".issues"}, issue_cnt - iss0, exp_iss);
    check_eq({tag, ".busy_during"}, int'(proto_ok), 1);
    @(negedge clk_in);
    check_eq({tag, ".idle_after"}, int'({valid_out, busy_out}), 0);
    check_eq({tag, ".result_held"}, int'(result_out), pow_ref(b, e));
  endtask

  initial begin
    int iss0;
    bit quiet;
    rst_n_in   = 1'b0;
    valid_in   = 1'b0;
    base_in    = '0;
    exp_in     = '0;
    r2_in      = '0;
    mm_busy_in = 1'b0;
    #1;
    check_eq("reset.ctrl", int'({valid_out, busy_out, mm_valid_out}), 0);
    check_eq("reset.data", int'({result_out, mm_a_out, mm_b_out}), 0);
    @(negedge clk_in);
    @(negedge clk_in);
    rst_n_in = 1'b1;

    run_exp("exp0d",     8'd7, 8'h0D, 0, 0);
    run_exp("exp0",      8'd7, 8'h00, 0, 0);
    run_exp("exp1",      8'd7, 8'h01, 0, 0);
    run_exp("base0",     8'd0, 8'hFF, 0, 0);
    run_exp("mm_busy",   8'd7, 8'h0D, 5, 0);
    run_exp("valid_mid", 8'd7, 8'h0D, 0, 20);
    run_exp("exp80",     8'd5, 8'h80, 0, 0);

    // Reset while the first SQUARE is outstanding.
    @(negedge clk_in);
    base_in  = 8'd7;
    exp_in   = 8'h0D;
    r2_in    = 8'(R2);
    valid_in = 1'b1;
    iss0     = issue_cnt;
    @(negedge clk_in);
    valid_in = 1'b0;
    for (int i = 0; i < 100 && issue_cnt < iss0 + 2; i++) @(negedge clk_in);
    check_eq("rst.reached_square", issue_cnt - iss0, 2);
    rst_n_in = 1'b0;
    #1;
    check_eq("rst.async_ctrl", int'({valid_out, busy_out, mm_valid_out}), 0);
    check_eq("rst.async_data", int'({result_out, mm_a_out, mm_b_out}), 0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_in);
      if (busy_out || valid_out || mm_valid_out || result_out != 0) quiet = 1'b0;
    end
    check_eq("rst.stale_ignored", int'(quiet), 1);
    run_exp("after_rst", 8'd7, 8'h0D, 0, 0);

    for (int i = 0; i < 200; i++) begin
      logic [7:0] b, e;
      b = 8'($urandom_range(0, N - 1));
      e = 8'($urandom_range(0, 255));
      run_exp("rand", b, e, 0, 0);
    end

    check_eq("single_outstanding", overlap_cnt, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
